rs_chien_forney: RTL

RS_CHIEN_FORNEY -- requirements
Module: rs_chien_forney

---
 rtl/rs_chien_forney_pkg.sv | 45 ++++
 rtl/gf256inv.sv | 23 ++
 rtl/gf256mul.sv | 13 +
 rtl/rs_chien_term.sv | 32 +++
 rtl/rs_chien_forney.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/rs_chien_forney_pkg.sv
// Shared RS package: GF(2^8) field constants, Chien-search constants,
// controller state encoding and a GF multiply helper.
package rs_chien_forney_pkg;

    localparam logic [8:0] GF_POLY  = 9'h11D;
    localparam int         NPOS_DEF = 255;

    // alpha^-1, alpha^-2, alpha^-3 for alpha = 0x02 over 0x11D
    localparam logic [7:0] ALPHA_INV1 = 8'h8E;
    localparam logic [7:0] ALPHA_INV2 = 8'h47;
    localparam logic [7:0] ALPHA_INV3 = 8'hAD;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // Shift-and-add product reduced by the field polynomial
    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            if (x[7]) x = {x[6:0], 1'b0} ^ GF_POLY[7:0];
            else      x = {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // Step multiplier for term j of the Chien search
    function automatic logic [7:0] alpha_neg(input int j);
        case (j)
            1:       return ALPHA_INV1;
            2:       return ALPHA_INV2;
            3:       return ALPHA_INV3;
            default: return 8'h01;
        endcase
    endfunction

endpackage

// File: rtl/gf256inv.sv
// Combinational GF(2^8) inverse as a^254; inv(0) yields 0.
// Square-and-multiply chain: a^2 * a^4 * ... * a^128.
module gf256inv
    import rs_chien_forney_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    // Accumulate successive squares into the running product
    always_comb begin
        logic [7:0] s;
        logic [7:0] r;
        s = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        y = r;
    end

endmodule

// File: rtl/gf256mul.sv
// Combinational GF(2^8) multiplier.
// Shares the field definition of the RS package.
module gf256mul
    import rs_chien_forney_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    assign p = gf_mul(a, b);

endmodule

// File: rtl/rs_chien_term.sv
// One Chien-search term pair: Lambda term t_j and Omega term u_j,
// each scaled by the constant MULT = alpha^-j on every search step.
module rs_chien_term
    import rs_chien_forney_pkg::*;
#(
    parameter logic [7:0] MULT = 8'h01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       step,
    input  logic [7:0] t_in,
    input  logic [7:0] u_in,
    output logic [7:0] t,
    output logic [7:0] u
);

    // Load coefficients, then advance x by alpha^-1 each step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t <= 8'h00;
            u <= 8'h00;
        end else if (load) begin
            t <= t_in;
            u <= u_in;
        end else if (step) begin
            t <= gf_mul(t, MULT);
            u <= gf_mul(u, MULT);
        end
    end

endmodule

// File: rtl/rs_chien_forney.sv
// Chien search plus Forney magnitude (b = 0): err = Omega / Lambda_odd.
// Search -> one pipeline stage -> registered error outputs.
module rs_chien_forney
    import rs_chien_forney_pkg::*;
#(
    parameter int NPOS = NPOS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kes_done,
    input  logic       kes_fail,
    input  logic [1:0] error_num,
    input  logic [7:0] elp0,
    input  logic [7:0] elp1,
    input  logic [7:0] elp2,
    input  logic [7:0] elp3,
    input  logic [7:0] evp0,
    input  logic [7:0] evp1,
    input  logic [7:0] evp2,
    input  logic [7:0] evp3,
    output logic       busy,
    output logic       err_valid,
    output logic [7:0] err_pos,
    output logic [7:0] err_val,
    output logic [1:0] err_cnt,
    output logic       done,
    output logic       fail
);

    state_t     state;
    logic [7:0] pos;
    logic       flush_cnt;
    logic [1:0] num_q;
    logic       load;
    logic       step;

    logic [7:0] elp_a [4];
    logic [7:0] evp_a [4];
    logic [7:0] t     [4];
    logic [7:0] u     [4];

    logic [7:0] lam;
    logic [7:0] omega;
    logic [7:0] lodd;

    logic       pp_vld;
    logic       pp_root;
    logic [7:0] pp_omega;
    logic [7:0] pp_lodd;
    logic [7:0] pp_pos;

    logic [7:0] lodd_inv;
    logic [7:0] prod;
    logic [2:0] root_cnt;
    logic       div_zero;

    assign elp_a[0] = elp0;
    assign elp_a[1] = elp1;
    assign elp_a[2] = elp2;
    assign elp_a[3] = elp3;
    assign evp_a[0] = evp0;
    assign evp_a[1] = evp1;
    assign evp_a[2] = evp2;
    assign evp_a[3] = evp3;

    assign load = (state == ST_IDLE) && kes_done
                  && !kes_fail && (error_num != 2'd0);
    assign step = (state == ST_SEARCH);

    for (genvar j = 0; j < 4; j++) begin : g_term
        rs_chien_term #(
            .MULT (alpha_neg(j))
        ) u_term (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load),
            .step  (step),
            .t_in  (elp_a[j]),
            .u_in  (evp_a[j]),
            .t     (t[j]),
            .u     (u[j])
        );
    end

    assign lam   = t[0] ^ t[1] ^ t[2] ^ t[3];
    assign omega = u[0] ^ u[1] ^ u[2] ^ u[3];
    assign lodd  = t[1] ^ t[3];

    gf256inv u_inv (
        .a (pp_lodd),
        .y (lodd_inv)
    );

    gf256mul u_mul (
        .a (pp_omega),
        .b (lodd_inv),
        .p (prod)
    );

    // Controller: idle / search / flush / done with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pos       <= 8'h00;
            flush_cnt <= 1'b0;
            num_q     <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            err_cnt   <= 2'd0;
        end else begin
            done <= 1'b0;
            fail <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (kes_done) begin
                        if (kes_fail || error_num == 2'd0) begin
                            state   <= ST_DONE;
                            done    <= 1'b1;
                            fail    <= kes_fail;
                            err_cnt <= 2'd0;
                        end else begin
                            state <= ST_SEARCH;
                            busy  <= 1'b1;
                            pos   <= 8'h00;
                            num_q <= error_num;
                        end
                    end
                end
                ST_SEARCH: begin
                    if (pos == 8'(NPOS - 1)) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= 1'b0;
                    end else begin
                        pos <= pos + 8'd1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt) begin
                        state   <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        err_cnt <= root_cnt[1:0];
                        fail    <= (root_cnt != {1'b0, num_q})
                                   || div_zero;
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pipeline stage: root flag, Omega, Lambda_odd and position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pp_vld   <= 1'b0;
            pp_root  <= 1'b0;
            pp_omega <= 8'h00;
            pp_lodd  <= 8'h00;
            pp_pos   <= 8'h00;
        end else begin
            pp_vld   <= step;
            pp_root  <= (lam == 8'h00);
            pp_omega <= omega;
            pp_lodd  <= lodd;
            pp_pos   <= pos;
        end
    end

    // Registered error report; position and value hold between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid <= 1'b0;
            err_pos   <= 8'h00;
            err_val   <= 8'h00;
        end else begin
            err_valid <= pp_vld && pp_root && (pp_lodd != 8'h00);
            if (pp_vld && pp_root && (pp_lodd != 8'h00)) begin
                err_pos <= pp_pos;
                err_val <= prod;
            end
        end
    end

    // Saturating root count and sticky zero-derivative flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            root_cnt <= 3'd0;
            div_zero <= 1'b0;
        end else if (load) begin
            root_cnt <= 3'd0;
            div_zero <= 1'b0;
        end else if (pp_vld && pp_root) begin
            if (root_cnt != 3'd7) root_cnt <= root_cnt + 3'd1;
            if (pp_lodd == 8'h00) div_zero <= 1'b1;
        end
    end

endmodule
